// File: rtl/ram_programmer_if.sv
// Host byte stream (valid/ready) plus the SAP RAM write/readback pins of the programmer.
// The master modport is the programmer side; the slave modport is the host/RAM side.
interface ram_programmer_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_write_enable;
    logic                  mem_enable;
    logic [DATA_WIDTH-1:0] mem_bus;

    modport master (
        input  in_data, in_valid, mem_bus,
        output in_ready, mem_address, mem_data, mem_write_enable, mem_enable
    );

    modport slave (
        output in_data, in_valid, mem_bus,
        input  in_ready, mem_address, mem_data, mem_write_enable, mem_enable
    );
endinterface

// File: rtl/ram_programmer.sv
// Write-side initiator for the SAP RAM: sequences a byte stream into addresses 0..DEPTH-1.
// Optional readback checksum verify is enabled by defining PROGRAMMER_VERIFY_EN.
module ram_programmer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int WE_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    ram_programmer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             error
);
    localparam int WE_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [WE_W-1:0]       WE_LAST   = WE_W'(WE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
    localparam logic [WE_W-1:0]       WE_ONE    = WE_W'(1'b1);

`ifdef PROGRAMMER_VERIFY_EN
    typedef enum logic [3:0] {
        ST_IDLE, ST_LOAD, ST_SETUP, ST_STROBE, ST_HOLD, ST_FINISH,
        ST_RD_SETUP, ST_RD_SAMPLE, ST_CHECK
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_SETUP, ST_STROBE, ST_HOLD, ST_FINISH
    } state_t;
`endif

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic [WE_W-1:0]       we_cnt_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  we_n_r;
    logic                  en_n_r;
    logic                  ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  error_r;
`ifdef PROGRAMMER_VERIFY_EN
    logic [DATA_WIDTH-1:0] wr_sum_r;
    logic [DATA_WIDTH-1:0] rd_sum_r;
`else
    logic                  unused_bus_s;
    assign unused_bus_s = ^bus.mem_bus;
`endif

    // Sequencer: state, counters and every output come from this one register bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            we_cnt_r <= '0;
            addr_r   <= '0;
            data_r   <= '0;
            we_n_r   <= 1'b1;
            en_n_r   <= 1'b1;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            error_r  <= 1'b0;
`ifdef PROGRAMMER_VERIFY_EN
            wr_sum_r <= '0;
            rd_sum_r <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r   <= '0;
                        error_r <= 1'b0;
                        busy_r  <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= ST_LOAD;
`ifdef PROGRAMMER_VERIFY_EN
                        wr_sum_r <= '0;
                        rd_sum_r <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid && ready_r) begin
                        data_r  <= bus.in_data;
                        addr_r  <= cnt_r;
                        ready_r <= 1'b0;
                        state_r <= ST_SETUP;
`ifdef PROGRAMMER_VERIFY_EN
                        wr_sum_r <= wr_sum_r ^ bus.in_data;
`endif
                    end
                end
                ST_SETUP: begin
                    we_n_r   <= 1'b0;
                    we_cnt_r <= '0;
                    state_r  <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (we_cnt_r == WE_LAST) begin
                        we_n_r  <= 1'b1;
                        state_r <= ST_HOLD;
                    end else begin
                        we_cnt_r <= we_cnt_r + WE_ONE;
                    end
                end
                ST_HOLD: begin
                    // The counter stops at the last address rather than wrapping.
                    if (cnt_r == LAST_ADDR) begin
`ifdef PROGRAMMER_VERIFY_EN
                        cnt_r   <= '0;
                        addr_r  <= '0;
                        en_n_r  <= 1'b0;
                        state_r <= ST_RD_SETUP;
`else
                        done_r  <= 1'b1;
                        state_r <= ST_FINISH;
`endif
                    end else begin
                        cnt_r   <= cnt_r + ADDR_ONE;
                        ready_r <= 1'b1;
                        state_r <= ST_LOAD;
                    end
                end
`ifdef PROGRAMMER_VERIFY_EN
                ST_RD_SETUP: begin
                    state_r <= ST_RD_SAMPLE;
                end
                ST_RD_SAMPLE: begin
                    rd_sum_r <= rd_sum_r ^ bus.mem_bus;
                    if (cnt_r == LAST_ADDR) begin
                        en_n_r  <= 1'b1;
                        state_r <= ST_CHECK;
                    end else begin
                        cnt_r   <= cnt_r + ADDR_ONE;
                        addr_r  <= cnt_r + ADDR_ONE;
                        state_r <= ST_RD_SETUP;
                    end
                end
                ST_CHECK: begin
                    error_r <= (wr_sum_r != rd_sum_r);
                    done_r  <= 1'b1;
                    state_r <= ST_FINISH;
                end
`endif
                ST_FINISH: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    we_n_r  <= 1'b1;
                    en_n_r  <= 1'b1;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready         = ready_r;
    assign bus.mem_address      = addr_r;
    assign bus.mem_data         = data_r;
    assign bus.mem_write_enable = we_n_r;
    assign bus.mem_enable       = en_n_r;
    assign busy                 = busy_r;
    assign done                 = done_r;
    assign error                = error_r;
endmodule

// File: tb/tb_ram_programmer.sv
// Self-checking bench for ram_programmer: behavioural RAM, per-cycle write-strobe checker
// and directed passes (throughput, stall, start-while-busy, mid-pass reset, optional verify).
module tb_ram_programmer;
    localparam int WE = 1;
`ifdef PROGRAMMER_VERIFY_EN
    localparam int EXP_CYC = 64 + 33;
`else
    localparam int EXP_CYC = 64;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;
    logic error;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] ram [16];
    logic [7:0] cur_tab [16];
    logic       corrupt = 1'b0;

    ram_programmer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) pif ();

    ram_programmer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .WE_CYCLES(WE)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (pif.master),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SAP RAM: writes while write_enable is low, drives bus_out while enable is low.
    always @(posedge clk) begin
        if (pif.mem_write_enable === 1'b0) ram[pif.mem_address] <= pif.mem_data;
    end
    assign pif.mem_bus = (pif.mem_enable === 1'b0) ?
        ((corrupt && pif.mem_address == 4'd5) ? 8'hCD : ram[pif.mem_address]) : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle model: the k-th strobe of a pass must write cur_tab[k] to address k.
    int   exp_idx  = 0;
    int   low_run  = 0;
    int   strobes  = 0;
    int   done_cnt = 0;
    logic prev_we  = 1'b1;
    logic prev_done = 1'b0;
    logic [3:0] prev_addr = 4'd0;
    logic [7:0] prev_data = 8'd0;

    always @(negedge clk) begin
        if (reset) begin
            prev_we   = 1'b1;
            prev_done = 1'b0;
            low_run   = 0;
            exp_idx   = 0;
        end else begin
            if (!busy) exp_idx = 0;
            chk("ready_only_when_loading", pif.in_ready & ~(pif.mem_write_enable & busy), 32'd0);
`ifdef PROGRAMMER_VERIFY_EN
            chk("enable_high_while_writing", pif.mem_enable | pif.mem_write_enable, 32'd1);
`else
            chk("enable_held_high", pif.mem_enable, 32'd1);
            chk("error_tied_low", error, 32'd0);
`endif
            if (prev_done) chk("busy_falls_after_done", busy, 32'd0);
            if (done) begin
                done_cnt++;
                chk("busy_during_finish", busy, 32'd1);
            end
            if (pif.mem_write_enable === 1'b0) begin
                chk("strobe_address", pif.mem_address, exp_idx % 16);
                chk("strobe_data", pif.mem_data, cur_tab[exp_idx % 16]);
                if (prev_we) begin
                    chk("setup_address_stable", pif.mem_address, prev_addr);
                    chk("setup_data_stable", pif.mem_data, prev_data);
                    strobes++;
                end
                low_run++;
            end else if (!prev_we) begin
                chk("strobe_width", low_run, WE);
                chk("hold_address_stable", pif.mem_address, prev_addr);
                chk("hold_data_stable", pif.mem_data, prev_data);
                low_run = 0;
                exp_idx++;
            end
            prev_we   = pif.mem_write_enable;
            prev_done = done;
            prev_addr = pif.mem_address;
            prev_data = pif.mem_data;
        end
    end

    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        pif.in_data  = d;
        pif.in_valid = 1'b1;
        while (pif.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_budget", (n < 40), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_pass(input int stall_at, input int poke_at, output int cycles);
        int t0;
        int n;
        int s0;
        int d0;
        d0 = done_cnt;
        s0 = strobes;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            if (k == stall_at) begin
                int st;
                pif.in_valid = 1'b0;
                n = 0;
                while (pif.in_ready !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                st = strobes;
                for (int j = 0; j < 5; j++) begin
                    chk("stall_in_ready", pif.in_ready, 32'd1);
                    chk("stall_no_write", pif.mem_write_enable, 32'd1);
                    @(negedge clk);
                end
                chk("stall_no_strobe", strobes - st, 32'd0);
            end
            send_byte(cur_tab[k]);
            if (k == poke_at) begin
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        pif.in_valid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", (n < 300), 32'd1);
        cycles = cyc - t0;
        chk("error_at_done", error, corrupt);
        // A start during the FINISH cycle must not launch a new pass.
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("finish_start_ignored_busy", busy, 32'd0);
        @(negedge clk);
        chk("idle_after_pass_busy", busy, 32'd0);
        chk("idle_after_pass_ready", pif.in_ready, 32'd0);
        chk("one_done_per_pass", done_cnt - d0, 32'd1);
        chk("sixteen_strobes", strobes - s0, 32'd16);
        for (int a = 0; a < 16; a++) chk("ram_image", ram[a], cur_tab[a]);
    endtask

    initial begin
        int cycles;
        int n;
        logic [7:0] keep8;
        reset        = 1'b1;
        start        = 1'b0;
        pif.in_valid = 1'b0;
        pif.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_address", pif.mem_address, 32'd0);
        chk("reset_data", pif.mem_data, 32'd0);
        chk("reset_we", pif.mem_write_enable, 32'd1);
        chk("reset_en", pif.mem_enable, 32'd1);
        chk("reset_ready", pif.in_ready, 32'd0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_done", done, 32'd0);
        chk("reset_error", error, 32'd0);
        reset = 1'b0;

        // Pass 1: 0x00..0x0F with 0xAA at 2 and 0xCC at 5, in_valid held high.
        for (int i = 0; i < 16; i++) cur_tab[i] = 8'(i);
        cur_tab[2] = 8'hAA;
        cur_tab[5] = 8'hCC;
        run_pass(-1, -1, cycles);
        chk("pass1_cycles", cycles, EXP_CYC);
        chk("ram_addr2_literal", ram[2], 32'hAA);
        chk("ram_addr5_literal", ram[5], 32'hCC);
        chk("ram_addr15_literal", ram[15], 32'h0F);

        // Pass 2: new data, 5-cycle stall before byte 3, start poked mid-pass.
        for (int i = 0; i < 16; i++) cur_tab[i] = 8'hF0 ^ 8'(i);
        run_pass(3, 9, cycles);
        chk("pass2_cycles_with_stall", cycles, EXP_CYC + 5);
        chk("ram_addr3_literal", ram[3], 32'hF3);
        chk("ram_addr9_literal", ram[9], 32'hF9);

        // Pass 3: reset during the strobe of address 7.
        for (int i = 0; i < 16; i++) cur_tab[i] = 8'h50 + 8'(i);
        keep8 = ram[8];
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 8; k++) send_byte(cur_tab[k]);
        pif.in_valid = 1'b0;
        n = 0;
        while (!(pif.mem_write_enable === 1'b0 && pif.mem_address == 4'd7) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_strobe7", (n < 20), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_we_high", pif.mem_write_enable, 32'd1);
        chk("abort_busy", busy, 32'd0);
        chk("abort_ready", pif.in_ready, 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", busy, 32'd0);
        chk("abort_partial_kept", ram[6], 32'h56);
        chk("abort_untouched", ram[8], keep8);

        // Pass 4: restart from address 0; with verify the RAM model corrupts address 5.
        for (int i = 0; i < 16; i++) cur_tab[i] = 8'h30 + 8'(i);
        cur_tab[5] = 8'hCC;
`ifdef PROGRAMMER_VERIFY_EN
        corrupt = 1'b1;
`endif
        run_pass(-1, -1, cycles);
        chk("pass4_cycles", cycles, EXP_CYC);
        chk("ram_addr0_literal", ram[0], 32'h30);
        corrupt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_programmer.md
Name: ram_programmer

Overview:
- Write-side initiator for the 16x8 SAP RAM. Takes a byte stream over a valid/ready handshake and sequences it into RAM addresses 0..DEPTH-1.
- Drives the RAM's address, data and active-low write_enable/enable pins with defined setup, strobe and hold phases.
- Replaces manual switch programming at power-up; sits between the host/loader interface and the RAM.

Parameters:
- ADDR_WIDTH, 4: RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8: RAM word width.
- WE_CYCLES, 1: cycles mem_write_enable is held low per write; legal range >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a programming pass; sampled only in IDLE.
- in_data  input  DATA_WIDTH  byte to be written.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- mem_address  output  ADDR_WIDTH  RAM address.
- mem_data  output  DATA_WIDTH  RAM write data.
- mem_write_enable  output  1  active-low RAM write strobe.
- mem_enable  output  1  active-low RAM output enable.
- mem_bus  input  DATA_WIDTH  RAM bus_out (readback; used only with the optional feature).
- busy  output  1  programming pass in progress.
- done  output  1  one-cycle pulse at the end of a pass.
- error  output  1  verify mismatch, sticky.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: mem_address=0, mem_data=0, mem_write_enable=1, mem_enable=1, in_ready=0, busy=0, done=0, error=0, state=IDLE.
- IDLE
  - start=1: address counter cleared to 0, error cleared, busy=1, go to LOAD.
  - start=0: stay in IDLE.
- LOAD
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into mem_data, drive mem_address=counter, go to SETUP.
  - in_valid=0: stall indefinitely; outputs hold.
- SETUP: in_ready=0, mem_write_enable=1 for one cycle (address/data setup).
- STROBE: mem_write_enable=0 for exactly WE_CYCLES cycles; mem_address and mem_data stable throughout.
- HOLD: mem_write_enable=1 for one cycle; mem_address and mem_data still stable.
  - Counter == DEPTH-1: go to FINISH.
  - Otherwise: increment counter, go to LOAD.
- Throughput: with in_valid held high, each byte takes 3+WE_CYCLES cycles. WE_CYCLES=1, DEPTH=16 gives 64 cycles from the first LOAD to FINISH.
- FINISH: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Counter never wraps; the pass ends after address DEPTH-1.
- mem_enable=1 in all write states; the bus is never read while writing.
- start while busy is ignored, including a start in the FINISH cycle.
- in_ready is 0 in every state except LOAD.
- Reset mid-pass aborts on the next edge.
  - mem_write_enable returns to 1 immediately.
  - Partially written RAM contents are left as they are.
- No combinational path from in_valid to in_ready.

Optional Feature:
- Macro: PROGRAMMER_VERIFY_EN.
- Defined:
  - A running XOR checksum of accepted bytes is kept; it is cleared on start.
  - After HOLD of address DEPTH-1, go to RD_SETUP instead of FINISH, with the counter cleared to 0.
  - RD_SETUP (1 cycle): mem_address=counter, mem_enable=0.
  - RD_SAMPLE (1 cycle): mem_enable=0; XOR mem_bus into a readback checksum.
    - Counter == DEPTH-1: go to CHECK.
    - Otherwise: increment counter, go to RD_SETUP.
  - CHECK: error=1 if the checksums differ; go to FINISH.
  - error stays sticky until the next start or reset.
  - mem_write_enable=1 throughout readback.
  - Pass length grows by 2*DEPTH+1 cycles.
- Undefined:
  - No readback states exist.
  - error tied 0; mem_enable held 1.
  - mem_bus unused.

Test Plan:
- Reset held 2 cycles -> all outputs at reset values; mem_write_enable=1, mem_enable=1, busy=0.
- start pulse, then 16 bytes 0x00..0x0F with in_valid high except address 2=0xAA and address 5=0xCC. Behavioural RAM model reads 0xAA at 0x2 and 0xCC at 0x5.
  - Exactly 16 write strobes, each 1 cycle low, address/data stable from SETUP through HOLD.
  - done pulses once; busy falls the next cycle; total 64 cycles LOAD-to-FINISH.
- in_valid deasserted for 5 cycles before byte 3 -> block stalls in LOAD with in_ready=1 and mem_write_enable=1; no spurious write; byte 3 lands at address 3.
- Reset asserted during STROBE of address 7 -> mem_write_enable=1 on the next edge; state IDLE; a subsequent start restarts at address 0.
- start pulsed while busy -> ignored; counter and data sequence unaffected.
- PROGRAMMER_VERIFY_EN defined, RAM model corrupts address 5 to 0xCD -> error=1 in the FINISH cycle alongside done. With the clean model -> error=0.
